// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared types for the counter command sequencer: the command opcodes seen
// on the host side, the controller state encoding and the default counter
// width.
package counter_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_UP_TO   = 2'd1,
    OP_DOWN_TO = 2'd2,
    OP_HOLD    = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if
// Host-side command and status bundle of the counter sequencer.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/cmd_arg/cmd_sat : operation, argument, saturate-at-boundary flag
//   abort               : terminate a running UP_TO, DOWN_TO or HOLD
//   busy/done/sat_hit/aborted : controller status and completion report
// master = host side, slave = controller side.
interface counter_seq_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             cmd_sat;
  logic             abort;
  logic             busy;
  logic             done;
  logic             sat_hit;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_sat, abort,
    input  cmd_ready, busy, done, sat_hit, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_sat, abort,
    output cmd_ready, busy, done, sat_hit, aborted
  );

endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Command-driven sequencer for a WIDTH-bit up/down counter. Accepts one
// command per handshake (LOAD, UP_TO, DOWN_TO, HOLD), drives the counter's
// control inputs and reports completion with done/sat_hit/aborted.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   host       : command/status bundle (slave side)
//   load_n     : to counter, active-low load
//   data_load  : to counter, load value
//   ce         : to counter, count enable
//   up_down    : to counter, 1 = up, 0 = down
//   count_out  : from counter, current count
//   max_count  : from counter, count_out is all ones
//   zero       : from counter, count_out is zero
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  counter_seq_ctrl_if.slave   host,
  output logic                load_n,
  output logic [WIDTH-1:0]    data_load,
  output logic                ce,
  output logic                up_down,
  input  logic [WIDTH-1:0]    count_out,
  input  logic                max_count,
  input  logic                zero
);

  state_e           state, state_nxt;
  cmd_op_e          op_q;
  logic [WIDTH-1:0] arg_q;
  logic             sat_q;
  logic [WIDTH-1:0] hold_cnt;
  logic             sat_hit_q, sat_hit_nxt;
  logic             aborted_q, aborted_nxt;
  logic             accept;
  logic             at_target;
  logic             stop;

  assign accept    = (state == ST_IDLE) && host.cmd_valid;
  assign at_target = (count_out == arg_q);
  // Saturating runs stop at the boundary in the direction of travel.
  assign stop      = sat_q && ((op_q == OP_UP_TO) ? max_count : zero);

  // Registered state, latched command and completion flags. The hold timer
  // is loaded with max(arg,1) so HOLD 0 still spends one cycle in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      arg_q     <= '0;
      sat_q     <= 1'b0;
      hold_cnt  <= '0;
      sat_hit_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      sat_hit_q <= sat_hit_nxt;
      aborted_q <= aborted_nxt;
      if (accept) begin
        op_q     <= cmd_op_e'(host.cmd_op);
        arg_q    <= host.cmd_arg;
        sat_q    <= host.cmd_sat;
        hold_cnt <= (host.cmd_arg == '0) ? WIDTH'(1) : host.cmd_arg;
      end else if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt - WIDTH'(1);
      end
    end
  end

  // Next-state and output decode. In RUN, reaching the target wins over
  // abort, which wins over the saturation stop, so a target that sits on
  // a boundary completes cleanly. Reset overrides every output last.
  always_comb begin
    state_nxt      = state;
    sat_hit_nxt    = sat_hit_q;
    aborted_nxt    = aborted_q;
    host.cmd_ready = 1'b0;
    host.busy      = (state != ST_IDLE);
    host.done      = 1'b0;
    host.sat_hit   = 1'b0;
    host.aborted   = 1'b0;
    load_n         = 1'b1;
    data_load      = '0;
    ce             = 1'b0;
    up_down        = 1'b1;

    case (state)
      ST_IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          sat_hit_nxt = 1'b0;
          aborted_nxt = 1'b0;
          case (cmd_op_e'(host.cmd_op))
            OP_LOAD: state_nxt = ST_LOAD;
            OP_HOLD: state_nxt = ST_HOLD;
            default: state_nxt = ST_RUN;
          endcase
        end
      end
      ST_LOAD: begin
        load_n    = 1'b0;
        data_load = arg_q;
        state_nxt = ST_DONE;
      end
      ST_RUN: begin
        up_down = (op_q == OP_UP_TO);
        ce      = !at_target && !stop && !host.abort;
        if (at_target) begin
          state_nxt = ST_DONE;
        end else if (host.abort) begin
          state_nxt   = ST_DONE;
          aborted_nxt = 1'b1;
        end else if (stop) begin
          state_nxt   = ST_DONE;
          sat_hit_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt <= WIDTH'(1)) begin
          state_nxt = ST_DONE;
        end else if (host.abort) begin
          state_nxt   = ST_DONE;
          aborted_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        host.done    = 1'b1;
        host.sat_hit = sat_hit_q;
        host.aborted = aborted_q;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (rst) begin
      host.cmd_ready = 1'b0;
      host.busy      = 1'b0;
      host.done      = 1'b0;
      host.sat_hit   = 1'b0;
      host.aborted   = 1'b0;
      load_n         = 1'b1;
      data_load      = '0;
      ce             = 1'b0;
      up_down        = 1'b1;
    end
  end

endmodule
